leb128_window: RTL and testbench

- Byte-serial front end for the combinational u32 LEB128 decoder (unpack_u32).
- Accepts a byte stream under a valid/ready handshake and holds it in a small shift buffer.
- Presents the oldest five bytes as the decoder inputs i0..i4.
- On a take strobe, retires exactly the number of bytes the decoder reports (its len output).

---
 rtl/leb128_window.sv | 101 ++++++++++
 tb/tb_leb128_window.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/leb128_window.sv
// Byte-serial front end for a u32 LEB128 decoder: linear shift buffer whose oldest five
// bytes form the decoder window; a take retires the decoder-reported length.
module leb128_window #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [7:0]    w0,
  output logic [7:0]    w1,
  output logic [7:0]    w2,
  output logic [7:0]    w3,
  output logic [7:0]    w4,
  output logic          win_valid,
  input  logic [2:0]    win_len,
  input  logic          win_take,
  output logic [CW-1:0] count,
  output logic          err
);

  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];
  // Buffer extended with five zero bytes so every shift source is in range.
  logic [7:0]    ext   [DEPTH+5];
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [CW-1:0] len_w, wr_idx;
  logic          term, push, len_ok, take_ok, take_bad;

  assign len_w    = CW'(win_len);
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign count    = count_q;
  assign err      = err_q;

  always_comb begin
    term = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      if ((CW'(k) < count_q) && !buf_q[k][7]) term = 1'b1;
    end
  end

  assign win_valid = term || (count_q >= CW'(5));
  assign len_ok    = (win_len >= 3'd1) && (win_len <= 3'd5) && (len_w <= count_q);
  assign take_ok   = win_take && win_valid && len_ok;
  assign take_bad  = win_take && win_valid && !len_ok;

  assign w0 = (count_q > CW'(0)) ? buf_q[0] : 8'h00;
  assign w1 = (count_q > CW'(1)) ? buf_q[1] : 8'h00;
  assign w2 = (count_q > CW'(2)) ? buf_q[2] : 8'h00;
  assign w3 = (count_q > CW'(3)) ? buf_q[3] : 8'h00;
  assign w4 = (count_q > CW'(4)) ? buf_q[4] : 8'h00;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH + 5; i++) begin
      ext[i] = (i < DEPTH) ? buf_q[i] : 8'h00;
    end
  end

  always_comb begin
    buf_d   = buf_q;
    count_d = count_q;
    err_d   = err_q;
    wr_idx  = take_ok ? (count_q - len_w) : count_q;
    if (take_ok) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned s = 1; s <= 5; s++) begin
          if (win_len == 3'(s)) buf_d[i] = ext[i+s];
        end
      end
    end
    // The push lands after the shift, at the post-take fill level.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && (wr_idx == CW'(i))) buf_d[i] = in_data;
    end
    count_d = wr_idx + (push ? CW'(1) : CW'(0));
    if (take_bad) err_d = 1'b1;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_d[i] = 8'h00;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_leb128_window.sv
// Bench for leb128_window: directed scenarios plus random traffic against a queue model.
module tb_leb128_window;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    w0, w1, w2, w3, w4;
  logic          win_valid;
  logic [2:0]    win_len = 3'd0;
  logic          win_take = 1'b0;
  logic [CW-1:0] count;
  logic          err;

  leb128_window #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
    .win_valid(win_valid), .win_len(win_len), .win_take(win_take), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];
  bit m_err = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_w(input int k);
    return (k < q.size()) ? q[k] : 8'h00;
  endfunction

  function automatic bit m_valid();
    for (int k = 0; k < 5 && k < q.size(); k++) if (!q[k][7]) return 1'b1;
    return q.size() >= 5;
  endfunction

  // Length a u32 LEB128 decoder would report for the current window.
  function automatic logic [2:0] m_dec_len();
    for (int k = 0; k < 5 && k < q.size(); k++) if (!q[k][7]) return 3'(k + 1);
    return 3'd5;
  endfunction

  function automatic logic [31:0] decode(input logic [7:0] a, b, c, d, e);
    logic [7:0] v[5];
    logic [31:0] r = 0;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    for (int k = 0; k < 5; k++) begin
      r = r | (32'(v[k][6:0]) << (7 * k));
      if (!v[k][7]) break;
    end
    return r;
  endfunction

  task automatic model_edge(input bit f, input bit iv, input logic [7:0] d,
                            input bit tk, input logic [2:0] ln);
    bit rdy, v, legal;
    if (f) begin
      q.delete();
      m_err = 1'b0;
      return;
    end
    rdy   = q.size() < DEPTH;
    v     = m_valid();
    legal = tk && v && ln >= 1 && ln <= 5 && int'(ln) <= q.size();
    if (legal) repeat (int'(ln)) void'(q.pop_front());
    if (tk && v && !legal) m_err = 1'b1;
    if (iv && rdy) q.push_back(d);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".count"}, 32'(count), 32'(q.size()));
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
    check_eq({tag, ".win_valid"}, 32'(win_valid), 32'(m_valid()));
    check_eq({tag, ".w0"}, 32'(w0), 32'(m_w(0)));
    check_eq({tag, ".w1"}, 32'(w1), 32'(m_w(1)));
    check_eq({tag, ".w2"}, 32'(w2), 32'(m_w(2)));
    check_eq({tag, ".w3"}, 32'(w3), 32'(m_w(3)));
    check_eq({tag, ".w4"}, 32'(w4), 32'(m_w(4)));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
  endtask

  // Drive one cycle's inputs (called at negedge), clock, then check at the next negedge.
  task automatic cyc(input string tag, input bit f, input bit iv, input logic [7:0] d,
                     input bit tk, input logic [2:0] ln);
    flush = f; in_valid = iv; in_data = d; win_take = tk; win_len = ln;
    @(posedge clk);
    model_edge(f, iv, d, tk, ln);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; win_take = 1'b0; win_len = 3'd0;
    check_all(tag);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #10;
    check_eq("rst.count", 32'(count), 0);
    check_eq("rst.in_ready", 32'(in_ready), 1);
    check_eq("rst.win_valid", 32'(win_valid), 0);
    check_eq("rst.w0", 32'(w0), 0);
    check_eq("rst.w4", 32'(w4), 0);
    check_eq("rst.err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("idle", 0, 0, 8'h00, 0, 3'd0);

    cyc("single_push", 0, 1, 8'h2a, 0, 3'd0);
    check_eq("single.w0", 32'(w0), 32'h2a);
    check_eq("single.valid", 32'(win_valid), 1);
    cyc("single_take", 0, 0, 8'h00, 1, 3'd1);
    check_eq("single.count_after", 32'(count), 0);

    cyc("multi_e5", 0, 1, 8'he5, 0, 3'd0);
    check_eq("multi.valid_e5", 32'(win_valid), 0);
    cyc("multi_8e", 0, 1, 8'h8e, 0, 3'd0);
    check_eq("multi.valid_8e", 32'(win_valid), 0);
    cyc("multi_26", 0, 1, 8'h26, 0, 3'd0);
    check_eq("multi.valid_26", 32'(win_valid), 1);
    check_eq("multi.decode", decode(w0, w1, w2, w3, w4), 32'd624485);
    cyc("multi_take", 0, 0, 8'h00, 1, 3'd3);
    check_eq("multi.count_after", 32'(count), 0);

    for (int i = 0; i < 8; i++) begin
      cyc("fill_80", 0, 1, 8'h80, 0, 3'd0);
      check_eq("fill.valid", 32'(win_valid), 32'(i + 1 >= 5));
    end
    check_eq("full.in_ready", 32'(in_ready), 0);
    cyc("full_9th", 0, 1, 8'h11, 0, 3'd0);
    check_eq("full.count", 32'(count), 8);
    cyc("overlong_take", 0, 0, 8'h00, 1, 3'd5);
    check_eq("overlong.count", 32'(count), 3);
    check_eq("overlong.w2", 32'(w2), 32'h80);
    check_eq("overlong.w3", 32'(w3), 0);

    cyc("flush1", 1, 0, 8'h00, 0, 3'd0);
    cyc("sim_05", 0, 1, 8'h05, 0, 3'd0);
    cyc("sim_07", 0, 1, 8'h07, 0, 3'd0);
    cyc("sim_take_push", 0, 1, 8'h09, 1, 3'd1);
    check_eq("sim.count", 32'(count), 2);
    check_eq("sim.w0", 32'(w0), 32'h07);
    check_eq("sim.w1", 32'(w1), 32'h09);

    cyc("flush2", 1, 1, 8'h44, 1, 3'd1);
    cyc("ill_05", 0, 1, 8'h05, 0, 3'd0);
    cyc("ill_take", 0, 0, 8'h00, 1, 3'd3);
    check_eq("ill.count", 32'(count), 1);
    check_eq("ill.err", 32'(err), 1);
    cyc("ill_flush", 1, 0, 8'h00, 0, 3'd0);
    check_eq("ill.flush_err", 32'(err), 0);
    check_eq("ill.flush_count", 32'(count), 0);

    cyc("pre_rst", 0, 1, 8'h12, 0, 3'd0);
    in_valid = 1'b1; in_data = 8'h33;
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst.count", 32'(count), 0);
    q.delete();
    m_err = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all("post_rst");

    for (int n = 0; n < 3000; n++) begin
      bit f, iv, tk;
      logic [7:0] d;
      logic [2:0] ln;
      f  = ($urandom % 64) == 0;
      iv = ($urandom % 4) != 0;
      d  = 8'($urandom);
      d[7] = ($urandom % 10) < 6;
      tk = ($urandom % 3) == 0;
      ln = (($urandom % 8) == 0) ? 3'($urandom % 8) : m_dec_len();
      cyc("rand", f, iv, d, tk, ln);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
